// File: rtl/cache_access_arbiter.sv
// cache_access_arbiter
//   Round-robin front end that lets two clients share one direct-mapped cache.
//   Each access runs IDLE -> ISSUE -> RESP: the request is accepted in IDLE,
//   one cache strobe is driven in ISSUE, and the cache's registered hit/data
//   go back to the owning requester in RESP. Saturating hit and miss counters
//   are kept for performance monitoring.
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   rN_valid/ready/we/addr/wdata   request channel of requester N (0 or 1)
//   rN_rvalid/rdata/hit       response of requester N (one-cycle rvalid pulse)
//   c_read_enable/c_write_enable/c_address/c_write_data   cache request side
//   c_read_data, c_hit        cache registered response
//   cnt_clear                 synchronous clear of both counters
//   hit_count, miss_count     saturating performance counters
module cache_access_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_hit,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_hit,
  output logic              c_read_enable,
  output logic              c_write_enable,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_write_data,
  input  logic [DATA_W-1:0] c_read_data,
  input  logic              c_hit,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              last_grant;  // requester that won the most recent accept
  logic              owner;       // requester owning the in-flight access
  logic              we_q;
  logic              hit_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              sel_we;

  // Grant only in IDLE; under contention the requester that did not win last
  // time goes first. The two terms are mutually exclusive by construction.
  assign r0_ready = (state == IDLE) & r0_valid & (~r1_valid | last_grant);
  assign r1_ready = (state == IDLE) & r1_valid & (~r0_valid | ~last_grant);
  assign accept   = r0_ready | r1_ready;
  assign sel_we   = r1_ready ? r1_we : r0_we;

  // The cache's response is live during RESP; afterwards the captured copy
  // keeps the outputs steady until the next access completes.
  assign r0_hit   = (state == RESP) ? c_hit : hit_q;
  assign r1_hit   = r0_hit;
  assign r0_rdata = (state == RESP) ? c_read_data : rdata_q;
  assign r1_rdata = r0_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      we_q           <= 1'b0;
      hit_q          <= 1'b0;
      rdata_q        <= '0;
      c_read_enable  <= 1'b0;
      c_write_enable <= 1'b0;
      c_address      <= '0;
      c_write_data   <= '0;
      r0_rvalid      <= 1'b0;
      r1_rvalid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner          <= r1_ready;
            last_grant     <= r1_ready;
            we_q           <= sel_we;
            c_address      <= r1_ready ? r1_addr  : r0_addr;
            c_write_data   <= r1_ready ? r1_wdata : r0_wdata;
            c_read_enable  <= ~sel_we;
            c_write_enable <= sel_we;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          c_read_enable  <= 1'b0;
          c_write_enable <= 1'b0;
          r0_rvalid      <= ~owner;
          r1_rvalid      <= owner;
          state          <= RESP;
        end
        RESP: begin
          hit_q     <= c_hit;
          rdata_q   <= c_read_data;
          r0_rvalid <= 1'b0;
          r1_rvalid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cnt_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (c_hit) begin
        if (~&hit_count) hit_count <= hit_count + CNT_ONE;
      end else begin
        if (~&miss_count) miss_count <= miss_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Bench for cache_access_arbiter: a behavioural cache with 16-byte lines
// answers the strobes, expected responses are queued at grant time and
// compared when rvalid pulses. Counters are built 4 bits wide so saturation
// is reachable in a few accesses.
module tb_cache_access_arbiter;
  localparam int AW = 22, DW = 32, CW = 4;

  logic clk = 1'b0, resetn = 1'b0;
  logic r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0, cnt_clear = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_hit, r1_hit;
  logic [DW-1:0] r0_rdata, r1_rdata, c_write_data;
  logic c_read_enable, c_write_enable;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_read_data = '0;
  logic c_hit = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  cache_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_hit(r0_hit),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_hit(r1_hit),
    .c_read_enable(c_read_enable), .c_write_enable(c_write_enable),
    .c_address(c_address), .c_write_data(c_write_data),
    .c_read_data(c_read_data), .c_hit(c_hit),
    .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          hit;
    logic [31:0] rdata;
    bit          chk_data;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_err = 0;
  int   rv0 = 0, rv1 = 0;

  bit          line_v[int];
  logic [31:0] mem[int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Cache model: registers hit/data on a strobe, allocates on miss.
  always @(posedge clk) begin
    if (c_read_enable || c_write_enable) begin
      int ln, wd;
      ln = int'(c_address >> 4);
      wd = int'(c_address >> 2);
      c_hit       <= line_v.exists(ln);
      c_read_data <= mem.exists(wd) ? mem[wd] : 32'h0;
      line_v[ln] = 1'b1;
      if (c_write_enable) mem[wd] = c_write_data;
    end
  end

  // Response monitor / scoreboard pop.
  always @(negedge clk) begin
    if (r0_rvalid || r1_rvalid) begin
      exp_t e;
      if (r0_rvalid) rv0++;
      if (r1_rvalid) rv1++;
      chk("rvalid_both", {31'b0, r0_rvalid & r1_rvalid}, 0);
      if (sbq.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("resp_port", {31'b0, r1_rvalid}, {31'b0, e.port});
        chk("resp_hit", {31'b0, e.port ? r1_hit : r0_hit}, {31'b0, e.hit});
        if (e.chk_data) chk("resp_rdata", e.port ? r1_rdata : r0_rdata, e.rdata);
      end
    end
  end

  function automatic exp_t predict(input bit p, input bit we, input logic [AW-1:0] a);
    exp_t e;
    e.port     = p;
    e.hit      = line_v.exists(int'(a >> 4));
    e.rdata    = mem.exists(int'(a >> 2)) ? mem[int'(a >> 2)] : 32'h0;
    e.chk_data = !we && e.hit;
    return e;
  endfunction

  // side: 0 plain, 1 pulse r1_valid during ISSUE, 2 cnt_clear in RESP,
  //       3 reset during ISSUE
  task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int side);
    int t = 0;
    @(negedge clk);
    if (p) begin r1_valid = 1; r1_we = we; r1_addr = a; r1_wdata = d; end
    else   begin r0_valid = 1; r0_we = we; r0_addr = a; r0_wdata = d; end
    #1;
    while (!(p ? r1_ready : r0_ready)) begin
      t++;
      if (t > 20) begin
        chk("ready_timeout", 0, 1);
        r0_valid = 0; r1_valid = 0;
        return;
      end
      @(negedge clk); #1;
    end
    chk("other_ready", {31'b0, p ? r0_ready : r1_ready}, 0);
    sbq.push_back(predict(p, we, a));
    @(negedge clk);  // ISSUE
    r0_valid = 0; r1_valid = 0;
    chk("rd_en", {31'b0, c_read_enable}, {31'b0, !we});
    chk("wr_en", {31'b0, c_write_enable}, {31'b0, we});
    chk("c_addr", {10'b0, c_address}, {10'b0, a});
    if (we) chk("c_wdata", c_write_data, d);
    if (side == 3) begin
      resetn = 0; #1;
      chk("rst_rd_en", {31'b0, c_read_enable}, 0);
      chk("rst_wr_en", {31'b0, c_write_enable}, 0);
      sbq.delete(sbq.size() - 1);
      @(negedge clk);
      resetn = 1;
      return;
    end
    if (side == 1) begin r1_valid = 1; r1_we = 0; r1_addr = 22'h2000; end
    @(negedge clk);  // RESP
    if (side == 1) r1_valid = 0;
    if (side == 2) cnt_clear = 1;
    @(negedge clk);  // back in IDLE
    cnt_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, b1, n, c;
    bit g[4];
    int w[4];

    // Reset state
    #12;
    chk("rst_rd_en", {31'b0, c_read_enable}, 0);
    chk("rst_wr_en", {31'b0, c_write_enable}, 0);
    chk("rst_addr", {10'b0, c_address}, 0);
    chk("rst_wdata", c_write_data, 0);
    chk("rst_rdata", r0_rdata, 0);
    chk("rst_hit", {31'b0, r0_hit}, 0);
    chk("rst_rvalid", {30'b0, r0_rvalid, r1_rvalid}, 0);
    chk("rst_hitcnt", {28'b0, hit_count}, 0);
    chk("rst_misscnt", {28'b0, miss_count}, 0);
    @(negedge clk); resetn = 1;

    // Cold read, then write and read back through the other port
    access(0, 0, 22'h000040, 0, 0);
    chk("cold_miss_cnt", {28'b0, miss_count}, 1);
    chk("cold_r1_quiet", rv1, 0);
    access(0, 1, 22'h000044, 32'hDEADBEEF, 0);
    access(1, 0, 22'h000044, 0, 0);
    chk("wr_rd_hit_cnt", {28'b0, hit_count}, 2);
    chk("wr_rd_miss_cnt", {28'b0, miss_count}, 1);

    // Miss counter saturates instead of wrapping (1 + 16 misses)
    for (int i = 0; i < 16; i++) access(0, 0, 22'h001000 + 22'(i * 16), 0, 0);
    chk("sat_miss_cnt", {28'b0, miss_count}, 15);
    chk("sat_hit_cnt", {28'b0, hit_count}, 2);

    // Clear during the RESP cycle of a hit beats the increment
    access(0, 0, 22'h000044, 0, 2);
    chk("clr_hit_cnt", {28'b0, hit_count}, 0);
    chk("clr_miss_cnt", {28'b0, miss_count}, 0);

    // Withdrawn r1 request while busy: no access, no response
    b1 = rv1;
    access(0, 0, 22'h000040, 0, 1);
    repeat (3) @(negedge clk);
    chk("withdrawn_rv1", rv1, b1);
    chk("withdrawn_alloc", {31'b0, line_v.exists(int'(22'h2000 >> 4))}, 0);
    chk("withdrawn_hit_cnt", {28'b0, hit_count}, 1);

    // Reset during ISSUE: no rvalid, counters cleared
    b0 = rv0; b1 = rv1;
    access(0, 0, 22'h000048, 0, 3);
    repeat (3) @(negedge clk);
    chk("rst_mid_rv0", rv0, b0);
    chk("rst_mid_rv1", rv1, b1);
    chk("rst_mid_hitcnt", {28'b0, hit_count}, 0);

    // Contention: grants alternate starting with r0, 3 cycles apart
    @(negedge clk);
    r0_valid = 1; r0_we = 0; r0_addr = 22'h000044;
    r1_valid = 1; r1_we = 0; r1_addr = 22'h000040;
    n = 0;
    c = 0;
    while (n < 4 && c < 30) begin
      #1;
      if (r0_ready || r1_ready) begin
        chk("cont_one_ready", {31'b0, r0_ready & r1_ready}, 0);
        g[n] = r1_ready;
        w[n] = c;
        sbq.push_back(predict(r1_ready, 0, r1_ready ? r1_addr : r0_addr));
        n++;
      end
      @(negedge clk);
      c++;
    end
    r0_valid = 0; r1_valid = 0;
    chk("cont_accepts", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), {31'b0, g[i]}, i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("cont_gap%0d", i), w[i] - w[i-1], 3);
    repeat (4) @(negedge clk);
    chk("cont_hit_cnt", {28'b0, hit_count}, 4);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_access_arbiter.md
# cache_access_arbiter

Two-requester front end for the direct-mapped cache. It arbitrates between two clients, for example instruction fetch and load/store, with round-robin priority. It drives one cache access at a time on the cache's enable, address and data inputs, then returns the cache's registered hit/read_data to the requester that owns the access. It also keeps saturating hit and miss counters for performance monitoring.

## Interface
Parameters:
- ADDR_W, 22, request/cache address width
- DATA_W, 32, data word width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  reset, asynchronous, active-low
- r0_valid  in  1  requester 0 has a request; must hold valid, we, addr and wdata stable until accepted
- r0_ready  out  1  requester 0 granted; a request is accepted on a cycle with valid & ready
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  ADDR_W  byte address
- r0_wdata  in  DATA_W  write data
- r0_rvalid  out  1  one-cycle response pulse, for reads and writes
- r0_rdata  out  DATA_W  read data, meaningful only when rvalid=1, we was 0 and hit=1
- r0_hit  out  1  cache hit status of the completed access, qualified by rvalid
- r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata, r1_hit: same as requester 0
- c_read_enable  out  1  cache read strobe
- c_write_enable  out  1  cache write strobe
- c_address  out  ADDR_W  cache address
- c_write_data  out  DATA_W  cache write data
- c_read_data  in  DATA_W  cache registered read data
- c_hit  in  1  cache registered hit flag
- cnt_clear  in  1  synchronous clear of both counters
- hit_count  out  CNT_W  number of hits
- miss_count  out  CNT_W  number of misses

## Operation
State machine with three states: IDLE, ISSUE, RESP.

IDLE:
- Only state in which ready may be high.
- ready is combinational from valid and last_grant.
- Only one valid: that requester gets ready=1.
- Both valid: the requester not equal to last_grant gets ready=1.
- At most one ready is ever high.
- On accept: latch owner, we, addr and wdata into c_address/c_write_data and internal registers; set last_grant=owner; go to ISSUE.

ISSUE:
- Exactly one of c_read_enable / c_write_enable is high, selected by the latched we, for exactly one cycle.
- Always go to RESP.

RESP:
- Sample c_hit and c_read_data; these are the values the cache registered at the end of ISSUE.
- Pulse rvalid on the owner only, with hit=c_hit and rdata=c_read_data.
- Increment hit_count if c_hit=1, else miss_count.
- Return to IDLE.

Output rules:
- rdata and hit are combinational from the registered response capture. They are driven on both ports, but only the owner's rvalid is asserted.
- c_address and c_write_data hold their last values outside ISSUE; both enables are 0 outside ISSUE.

Counters:
- Saturate at all-ones and never wrap.
- cnt_clear takes priority over an increment in the same cycle: the result is 0.

Cache misses:
- The cache allocates the line itself on a miss.
- The arbiter reports hit=0 and does not retry; data for a read miss is undefined to the requester.

## Timing
Reset values:
- state=IDLE, last_grant=1 (requester 0 wins first contention).
- All ready, rvalid and enable outputs 0.
- c_address, c_write_data, rdata, hit_count, miss_count all 0; hit 0.

Latency:
- Cycle 0: accept.
- Cycle 1: cache enable high.
- Cycle 2: rvalid.
- Next accept possible in cycle 3; sustained throughput is one access per 3 cycles.

Handshake and edge cases:
- ready never depends on rvalid.
- A requester may raise valid again in the same cycle its rvalid pulses.
- valid deasserted before accept is legal (request withdrawn) and must not cause an access.
- Reset asserted in any state: immediately returns to IDLE with enables dropped. An in-flight access gets no rvalid, and counters clear.

## Test plan
- Single read after reset, cold cache: r0 read 0x000040 → c_read_enable high in cycle 1 only, r0_rvalid in cycle 2 with r0_hit=0, miss_count=1, r1_rvalid never high.
- Write then read: r0 write 0x000044 with 0xDEADBEEF, then r1 read 0x000044 → write response hit=1; read response r1_hit=1, r1_rdata=0xDEADBEEF; hit_count=2.
- Contention: r0 and r1 valid continuously for 4 accesses → grant order r0, r1, r0, r1; accepts spaced exactly 3 cycles apart.
- Counter saturation and clear: force miss_count to 0xFFFF then perform a miss → stays 0xFFFF; cnt_clear in the RESP cycle of a hit → hit_count=0.
- Reset mid-operation: deassert resetn during ISSUE → enables drop at once, no rvalid; after release, the first contended grant goes to r0.
- Withdrawn request: r1_valid pulsed for one cycle while the arbiter is in ISSUE → no r1 access and no r1_rvalid.
